// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register offsets, the bridge
// state encoding and the default highest legal offset.
package gpio_pkg;

  localparam logic [31:0] RGPIO_IN    = 32'h00;
  localparam logic [31:0] RGPIO_OUT   = 32'h04;
  localparam logic [31:0] RGPIO_OE    = 32'h08;
  localparam logic [31:0] RGPIO_INTE  = 32'h0C;
  localparam logic [31:0] RGPIO_PTRIG = 32'h10;
  localparam logic [31:0] RGPIO_AUX   = 32'h14;
  localparam logic [31:0] RGPIO_CTRL  = 32'h18;
  localparam logic [31:0] RGPIO_INTS  = 32'h1C;
  localparam logic [31:0] RGPIO_ECLK  = 32'h20;
  localparam logic [31:0] RGPIO_NEC   = 32'h24;

  localparam logic [31:0] MAX_OFFS_DEF = RGPIO_NEC;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    RD_WAIT,
    RD_CAPT,
    RD_DONE,
    ERR_ACC
  } bridge_state_e;

endpackage

// File: rtl/gpio_addr_check.sv
// Combinational access checker for the GPIO bridge.
// Ports: offs (register offset), write (access kind), err (illegal).
module gpio_addr_check
  import gpio_pkg::*;
#(
  parameter logic [31:0] MAX_OFFS = MAX_OFFS_DEF
) (
  input  logic [31:0] offs,
  input  logic        write,
  output logic        err
);

  logic misaligned;
  logic out_of_range;
  logic ro_write;

  always_comb begin
    misaligned   = offs[1:0] != 2'b00;
    out_of_range = offs > MAX_OFFS;
    ro_write     = write && (offs == RGPIO_IN);
    err          = misaligned | out_of_range | ro_write;
  end

endmodule

// File: rtl/apb_gpio_bridge.sv
// APB3 slave front-end turning APB transfers into GPIO register strobes.
// Ports: sys_clk/sys_rst, APB slave (PSEL..PSLVERR), GPIO strobe side.
module apb_gpio_bridge
  import gpio_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] MAX_OFFS = MAX_OFFS_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        gpio_we,
  output logic [31:0] gpio_adr,
  output logic [31:0] gpio_dat_i,
  input  logic [31:0] gpio_dat_o
);

  bridge_state_e state;
  bridge_state_e state_nxt;

  logic [31:0] offs;
  logic        setup;
  logic        err;
  logic        latch;
  logic        we_nxt;
  logic        rdy_nxt;
  logic        slv_nxt;
  logic [31:0] rdata_nxt;
  logic        unused_paddr;

  // PSEL is decoded upstream, so upper address bits carry nothing.
  assign offs         = {{(32-ADDR_W){1'b0}}, PADDR[ADDR_W-1:0]};
  assign unused_paddr = ^PADDR[31:ADDR_W];
  assign setup        = PSEL & ~PENABLE;

  gpio_addr_check #(
    .MAX_OFFS(MAX_OFFS)
  ) u_chk (
    .offs (offs),
    .write(PWRITE),
    .err  (err)
  );

  // All outputs are registered: the values computed here are
  // what the outputs show during the cycle after the edge.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    we_nxt    = 1'b0;
    rdy_nxt   = 1'b0;
    slv_nxt   = 1'b0;
    rdata_nxt = '0;
    unique case (state)
      IDLE: begin
        if (setup) begin
          latch = 1'b1;
          unique case (1'b1)
            err: begin
              state_nxt = ERR_ACC;
              rdy_nxt   = 1'b1;
              slv_nxt   = 1'b1;
            end
            (~err & PWRITE): begin
              state_nxt = WR_ACC;
              we_nxt    = 1'b1;
              rdy_nxt   = 1'b1;
            end
            (~err & ~PWRITE): begin
              state_nxt = RD_WAIT;
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        state_nxt = PSEL ? RD_CAPT : IDLE;
      end
      RD_CAPT: begin
        // PRDATA itself is the hold register for the read data.
        if (PSEL) begin
          state_nxt = RD_DONE;
          rdy_nxt   = 1'b1;
          rdata_nxt = gpio_dat_o;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state      <= IDLE;
      PREADY     <= 1'b0;
      PRDATA     <= '0;
      PSLVERR    <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_adr   <= '0;
      gpio_dat_i <= '0;
    end else begin
      state   <= state_nxt;
      PREADY  <= rdy_nxt;
      PRDATA  <= rdata_nxt;
      PSLVERR <= slv_nxt;
      gpio_we <= we_nxt;
      if (latch) begin
        gpio_adr   <= offs;
        gpio_dat_i <= PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_gpio_bridge.sv
// Self-checking bench for apb_gpio_bridge with a GPIO register model.
// Directed table, randomized transfers and abort sequences.
module tb_apb_gpio_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        gpio_we;
  logic [31:0] gpio_adr;
  logic [31:0] gpio_dat_i;
  logic [31:0] gpio_dat_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  apb_gpio_bridge dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .gpio_we   (gpio_we),
    .gpio_adr  (gpio_adr),
    .gpio_dat_i(gpio_dat_i),
    .gpio_dat_o(gpio_dat_o)
  );

  function automatic logic [31:0] preset(int i);
    return (i == 7) ? 32'h0000_0080 : 32'hC0DE_0000 + i;
  endfunction

  // Register block environment: registered read port, write on strobe.
  logic [31:0] mem [16];
  bit          loaded = 1'b0;

  always @(posedge sys_clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= preset(i);
      loaded <= 1'b1;
    end else if (gpio_we) begin
      mem[gpio_adr[5:2]] <= gpio_dat_i;
    end
    gpio_dat_o <= mem[gpio_adr[5:2]];
  end

  // Reference model: what an APB master should observe per transfer.
  logic [31:0] shadow [16];

  function automatic void model(input bit wr, input logic [31:0] addr,
                                input logic [31:0] wd,
                                output logic [31:0] rd, output bit er,
                                output int lat);
    int off;
    off = int'(addr & 32'hFFF);
    er  = (addr % 4 != 0) || (off > 36) || (wr && off == 0);
    lat = (er || wr) ? 1 : 3;
    rd  = (er || wr) ? 32'h0 : shadow[off / 4];
    if (!er && wr) shadow[off / 4] = wd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge sys_clk);
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic run_vec(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input bit exp_err, input int exp_lat);
    int          lat;
    int          wec;
    logic [31:0] early;
    logic [31:0] adr1;
    logic [31:0] dat1;
    @(negedge sys_clk);
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = addr;
    PWDATA = wd;
    @(negedge sys_clk);
    PENABLE = 1'b1;
    lat = 1;
    wec = 0;
    early = '0;
    adr1 = gpio_adr;
    dat1 = gpio_dat_i;
    while (!PREADY && lat < 8) begin
      wec += int'(gpio_we);
      early |= PRDATA;
      @(negedge sys_clk);
      lat++;
    end
    wec += int'(gpio_we);
    chk("pready", 32'(PREADY), 32'd1);
    chk("latency", lat, exp_lat);
    chk("pslverr", 32'(PSLVERR), 32'(exp_err));
    chk("prdata", PRDATA, exp_rd);
    chk("we_count", wec, (wr && !exp_err) ? 1 : 0);
    chk("gpio_adr", adr1, addr & 32'hFFF);
    chk("gpio_dat_i", dat1, wd);
    chk("prdata_wait", early, 32'h0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;
    int          cnt;

    for (int i = 0; i < 16; i++) shadow[i] = preset(i);

    tbl.push_back('{1'b1, 32'h04, 32'hA5A5_0001, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h04, 32'h0, 32'hA5A5_0001, 1'b0, 3});
    tbl.push_back('{1'b1, 32'h00, 32'h1111_2222, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h28, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 32'h06, 32'h3333_4444, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 3});
    tbl.push_back('{1'b0, 32'h00, 32'h0, 32'hC0DE_0000, 1'b0, 3});
    tbl.push_back('{1'b1, 32'h24, 32'hFEED_0024, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h24, 32'h0, 32'hFEED_0024, 1'b0, 3});
    tbl.push_back('{1'b0, 32'h25, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h7000_3010, 32'h0, 32'hC0DE_0004, 1'b0, 3});

    repeat (3) @(negedge sys_clk);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_we", 32'(gpio_we), 32'd0);
    chk("rst_adr", gpio_adr, 32'h0);
    chk("rst_dat_i", gpio_dat_i, 32'h0);
    sys_rst = 1'b1;
    idle();

    // Back-to-back directed table.
    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, er, lat);
      run_vec(tbl[i].wr, tbl[i].addr, tbl[i].wd,
              tbl[i].rd, tbl[i].err, tbl[i].lat);
    end
    idle();
    chk("we_after_seq", 32'(gpio_we), 32'd0);

    // Write strobe must be a single cycle.
    model(1'b1, 32'h04, 32'hA5A5_0001, rd, er, lat);
    run_vec(1'b1, 32'h04, 32'hA5A5_0001, 32'h0, 1'b0, 1);
    idle();
    chk("wr_t2_we", 32'(gpio_we), 32'd0);
    chk("wr_t2_pready", 32'(PREADY), 32'd0);

    // Read 0x1C: data only in the completion cycle.
    run_vec(1'b0, 32'h1C, 32'h0, 32'h0000_0080, 1'b0, 3);
    idle();
    chk("rd1c_t4_prdata", PRDATA, 32'h0);
    chk("rd1c_t4_pready", 32'(PREADY), 32'd0);

    // Reset during T2 of a read.
    @(negedge sys_clk);
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = 32'h10;
    @(negedge sys_clk);
    PENABLE = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_rst_pready", 32'(PREADY), 32'd0);
    chk("abort_rst_prdata", PRDATA, 32'h0);
    chk("abort_rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("abort_rst_we", 32'(gpio_we), 32'd0);
    chk("abort_rst_adr", gpio_adr, 32'h0);
    chk("abort_rst_dat_i", gpio_dat_i, 32'h0);
    sys_rst = 1'b1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    model(1'b1, 32'h0C, 32'h0000_0C0C, rd, er, lat);
    run_vec(1'b1, 32'h0C, 32'h0000_0C0C, 32'h0, 1'b0, 1);

    // PSEL dropped in RD_WAIT: no completion at all.
    @(negedge sys_clk);
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = 32'h14;
    @(negedge sys_clk);
    PSEL = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge sys_clk);
      cnt += int'(PREADY);
    end
    chk("psel_drop_pready", cnt, 0);
    model(1'b0, 32'h0C, 32'h0, rd, er, lat);
    run_vec(1'b0, 32'h0C, 32'h0, rd, er, lat);

    // Randomized transfers against the reference model.
    for (int n = 0; n < 60; n++) begin
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      int          off;
      wr  = 1'($urandom);
      off = int'($urandom_range(0, 11)) * 4;
      if ($urandom_range(0, 3) == 0) off += int'($urandom_range(1, 3));
      addr = ($urandom & 32'hFFFF_F000) | 32'(off);
      wd   = $urandom;
      model(wr, addr, wd, rd, er, lat);
      run_vec(wr, addr, wd, rd, er, lat);
      if ($urandom_range(0, 2) == 0) idle();
    end

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
